// File: rtl/bcd_tick_counter_if.sv
// Bundle of the count/display signals exchanged with bcd_tick_counter.
// The master side drives the divided clock and the count controls; the
// slave side (the counter) returns the BCD count, wrap pulse and display.
interface bcd_tick_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    slow_clk;
  logic                    enable;
  logic                    up_down;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    carry;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [6:0]              segments;

  modport master (
    output slow_clk, enable, up_down, clear,
    input  count_bcd, carry, anodes, segments
  );

  modport slave (
    input  slow_clk, enable, up_down, clear,
    output count_bcd, carry, anodes, segments
  );
endinterface

// File: rtl/bcd_tick_counter.sv
// BCD up/down counter stepped by rising edges of a divided clock that is
// sampled as plain data in the clk_in domain, plus a time-multiplexed
// active-low 7-segment display driver for the running count.
module bcd_tick_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_COUNT = 100000
) (
  input  logic             i_clk_in,
  input  logic             i_reset,
  bcd_tick_counter_if.slave bus
);

  localparam int CNT_W  = 4 * NUM_DIGITS;
  localparam int SCAN_W = $clog2(SCAN_COUNT);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_COUNT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  logic              r_slow_q;
  logic [CNT_W-1:0]  r_count;
  logic              r_carry;
  logic [SCAN_W-1:0] r_scan;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_DIGITS-1:0] r_anodes;
  logic [6:0]        r_segments;

  logic                  w_step;
  logic [NUM_DIGITS:0]   w_up_chain;
  logic [NUM_DIGITS:0]   w_dn_chain;
  logic [CNT_W-1:0]      w_up_next;
  logic [CNT_W-1:0]      w_dn_next;
  logic [3:0]            w_digit [NUM_DIGITS];
  logic [3:0]            w_cur_digit;
  logic [NUM_DIGITS-1:0] w_anodes_next;

  // One step per slow_clk rising edge, independent of its high time.
  assign w_step = bus.slow_clk & ~r_slow_q;

  // Ripple chains: an increment propagates through trailing 9s, a
  // decrement through trailing 0s; the chain output is the wrap flag.
  assign w_up_chain[0] = 1'b1;
  assign w_dn_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit[gi]        = r_count[gi*4 +: 4];
      assign w_up_chain[gi+1]   = w_up_chain[gi] & (w_digit[gi] == 4'd9);
      assign w_dn_chain[gi+1]   = w_dn_chain[gi] & (w_digit[gi] == 4'd0);
      assign w_up_next[gi*4 +: 4] = !w_up_chain[gi]        ? w_digit[gi] :
                                    (w_digit[gi] == 4'd9) ? 4'd0 : w_digit[gi] + 4'd1;
      assign w_dn_next[gi*4 +: 4] = !w_dn_chain[gi]        ? w_digit[gi] :
                                    (w_digit[gi] == 4'd0) ? 4'd9 : w_digit[gi] - 4'd1;
    end
  endgenerate

  assign w_cur_digit   = w_digit[r_idx];
  assign w_anodes_next = ~(NUM_DIGITS'(1) << r_idx);

  // Edge detector history; resets high so a high slow_clk at release is ignored.
  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) r_slow_q <= 1'b1;
    else         r_slow_q <= bus.slow_clk;
  end

  // Count register and wrap pulse: clear beats a step, otherwise hold.
  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else if (bus.clear) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else if (w_step && bus.enable) begin
      if (bus.up_down) begin
        r_count <= w_up_next;
        r_carry <= w_up_chain[NUM_DIGITS];
      end else begin
        r_count <= w_dn_next;
        r_carry <= w_dn_chain[NUM_DIGITS];
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  // Free-running scan timer; advances the lit digit at its terminal value.
  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Anode and segment registers load together so they always describe one digit.
  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_anodes   <= '1;
      r_segments <= 7'h7F;
    end else begin
      r_anodes   <= w_anodes_next;
      r_segments <= seg_decode(w_cur_digit);
    end
  end

  assign bus.count_bcd = r_count;
  assign bus.carry     = r_carry;
  assign bus.anodes    = r_anodes;
  assign bus.segments  = r_segments;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: directed scenarios plus a
// randomized run, checked against an integer-valued reference model.
module tb_bcd_tick_counter;

  localparam int ND  = 4;
  localparam int SC  = 4;
  localparam int MOD = 10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_tick_counter_if #(.NUM_DIGITS(ND)) bus ();

  bcd_tick_counter #(.NUM_DIGITS(ND), .SCAN_COUNT(SC)) dut (
    .i_clk_in (clk),
    .i_reset  (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count is a plain integer modulo 10^ND; the lit digit
  // is derived from the number of clk edges since reset.
  int          m_count;
  logic        m_carry;
  logic        m_slow_q;
  int          m_k;
  logic [ND-1:0] m_anodes;
  logic [6:0]  m_seg;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tab[d];
  endfunction

  function automatic int digit_of(input int v, input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count  <= 0;
      m_carry  <= 1'b0;
      m_slow_q <= 1'b1;
      m_k      <= 0;
      m_anodes <= '1;
      m_seg    <= 7'h7F;
    end else begin
      m_slow_q <= bus.slow_clk;
      m_anodes <= ~(ND'(1) << ((m_k / SC) % ND));
      m_seg    <= seg_of(digit_of(m_count, (m_k / SC) % ND));
      m_k      <= m_k + 1;
      if (bus.clear) begin
        m_count <= 0;
        m_carry <= 1'b0;
      end else if (bus.enable && bus.slow_clk && !m_slow_q) begin
        if (bus.up_down) begin
          m_carry <= (m_count == MOD - 1);
          m_count <= (m_count + 1) % MOD;
        end else begin
          m_carry <= (m_count == 0);
          m_count <= (m_count + MOD - 1) % MOD;
        end
      end else begin
        m_carry <= 1'b0;
      end
    end
  end

  // One clock edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; bus.slow_clk = 1'b0;
    tick();
    bus.clear = 1'b0;
  endtask

  // Fast edges used only to move the count to a chosen start value.
  task automatic fast_edges(input int n);
    for (int i = 0; i < n; i++) begin
      bus.slow_clk = 1'b1; tick();
      bus.slow_clk = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.slow_clk = 1'b1; bus.enable = 1'b1; bus.up_down = 1'b1; bus.clear = 1'b0;
    #1;
    n_checks++;
    if (bus.count_bcd !== 16'h0000 || bus.carry !== 1'b0 ||
        bus.anodes !== 4'b1111 || bus.segments !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_state count=%h carry=%b anodes=%b seg=%h required 0000/0/1111/7f",
               bus.count_bcd, bus.carry, bus.anodes, bus.segments);
    end
    repeat (2) tick();
    rst = 1'b0;
    // slow_clk already high at release: must not step
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.count_bcd !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_release_step cycle=%0d count=%h required 0000", i, bus.count_bcd);
      end
    end
    n_checks++;
    if (bus.anodes !== m_anodes || bus.segments !== m_seg) begin
      n_fail++;
      $display("FAIL reset_first_display anodes=%b seg=%h required %b/%h",
               bus.anodes, bus.segments, m_anodes, m_seg);
    end
    $display("test_reset done");
  endtask

  task automatic test_count_up();
    int changes = 0;
    int carries = 0;
    int bad_lat = 0;
    logic [15:0] prev;
    do_clear();
    bus.enable = 1'b1; bus.up_down = 1'b1;
    prev = bus.count_bcd;
    for (int e = 0; e < 12; e++) begin
      for (int c = 0; c < 100; c++) begin
        bus.slow_clk = (c < 50);
        tick();
        n_checks++;
        if (bus.count_bcd !== to_bcd(m_count) || bus.carry !== m_carry) begin
          n_fail++;
          $display("FAIL count_up_track e=%0d c=%0d count=%h carry=%b required %h/%b",
                   e, c, bus.count_bcd, bus.carry, to_bcd(m_count), m_carry);
        end
        if (bus.count_bcd !== prev) begin
          changes++;
          if (c != 0) bad_lat++;
        end
        if (bus.carry) carries++;
        prev = bus.count_bcd;
      end
    end
    n_checks++;
    if (bus.count_bcd !== 16'h0012 || changes != 12 || carries != 0 || bad_lat != 0) begin
      n_fail++;
      $display("FAIL count_up_final count=%h changes=%0d carries=%0d late=%0d required 0012/12/0/0",
               bus.count_bcd, changes, carries, bad_lat);
    end
    $display("test_count_up count=%h updates=%0d", bus.count_bcd, changes);
  endtask

  task automatic test_wrap();
    int carries;
    do_clear();
    bus.enable = 1'b1;
    for (int dir = 0; dir < 2; dir++) begin
      bus.up_down = dir[0];
      carries = 0;
      for (int c = 0; c < 6; c++) begin
        bus.slow_clk = (c < 3);
        tick();
        if (bus.carry) carries++;
        n_checks++;
        if (bus.carry !== m_carry || bus.count_bcd !== to_bcd(m_count)) begin
          n_fail++;
          $display("FAIL wrap_track dir=%0d c=%0d count=%h carry=%b required %h/%b",
                   dir, c, bus.count_bcd, bus.carry, to_bcd(m_count), m_carry);
        end
      end
      n_checks++;
      if (bus.count_bcd !== (dir == 0 ? 16'h9999 : 16'h0000) || carries != 1) begin
        n_fail++;
        $display("FAIL wrap_final dir=%0d count=%h carry_cycles=%0d required %h/1",
                 dir, bus.count_bcd, carries, (dir == 0 ? 16'h9999 : 16'h0000));
      end
      $display("test_wrap dir=%0d count=%h carry_cycles=%0d", dir, bus.count_bcd, carries);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    bus.enable = 1'b1; bus.up_down = 1'b1;
    fast_edges(9);
    n_checks++;
    if (bus.count_bcd !== 16'h0009) begin
      n_fail++;
      $display("FAIL clear_setup count=%h required 0009", bus.count_bcd);
    end
    bus.slow_clk = 1'b1; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0; bus.slow_clk = 1'b0;
    n_checks++;
    if (bus.count_bcd !== 16'h0000 || bus.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_step count=%h carry=%b required 0000/0", bus.count_bcd, bus.carry);
    end
    tick();
    fast_edges(5);
    bus.enable = 1'b0;
    for (int e = 0; e < 5; e++) begin
      for (int c = 0; c < 4; c++) begin
        bus.slow_clk = (c < 2);
        tick();
        n_checks++;
        if (bus.count_bcd !== 16'h0005 || bus.carry !== 1'b0) begin
          n_fail++;
          $display("FAIL enable_hold e=%0d c=%0d count=%h carry=%b required 0005/0",
                   e, c, bus.count_bcd, bus.carry);
        end
      end
    end
    $display("test_clear_priority count=%h", bus.count_bcd);
  endtask

  task automatic test_scan();
    logic [3:0] exp_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{7'h40, 7'h10, 7'h24, 7'h79};
    int guard;
    do_clear();
    bus.enable = 1'b1; bus.up_down = 1'b1;
    fast_edges(1290);
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if (bus.count_bcd !== 16'h1290) begin
      n_fail++;
      $display("FAIL scan_setup count=%h required 1290", bus.count_bcd);
    end
    guard = 0;
    while (bus.anodes !== 4'b0111 && guard < 20) begin tick(); guard++; end
    while (bus.anodes !== 4'b1110 && guard < 20) begin tick(); guard++; end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL scan_align anodes=%b required 1110 within 20 cycles", bus.anodes);
    end
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if (bus.anodes !== exp_an[(j / 4) % 4] || bus.segments !== exp_seg[(j / 4) % 4] ||
          bus.anodes !== m_anodes || bus.segments !== m_seg) begin
        n_fail++;
        $display("FAIL scan_pattern j=%0d anodes=%b seg=%h required %b/%h",
                 j, bus.anodes, bus.segments, exp_an[(j / 4) % 4], exp_seg[(j / 4) % 4]);
      end
      tick();
    end
    $display("test_scan pattern checked over 32 cycles");
  endtask

  task automatic test_reset_mid();
    do_clear();
    bus.enable = 1'b1; bus.up_down = 1'b1;
    fast_edges(347);
    n_checks++;
    if (bus.count_bcd !== 16'h0347) begin
      n_fail++;
      $display("FAIL reset_mid_setup count=%h required 0347", bus.count_bcd);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.count_bcd !== 16'h0000 || bus.carry !== 1'b0 ||
        bus.anodes !== 4'b1111 || bus.segments !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_mid count=%h carry=%b anodes=%b seg=%h required 0000/0/1111/7f",
               bus.count_bcd, bus.carry, bus.anodes, bus.segments);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset_mid count=%h anodes=%b", bus.count_bcd, bus.anodes);
  endtask

  task automatic test_divider();
    int div_cnt = 0;
    logic div_out = 1'b0;
    int rises = 0;
    rst = 1'b1; bus.slow_clk = 1'b0;
    tick();
    rst = 1'b0;
    bus.enable = 1'b1; bus.up_down = 1'b1; bus.clear = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.slow_clk = div_out;
      tick();
      if (div_cnt == 4) begin
        div_cnt = 0;
        if (!div_out) rises++;
        div_out = ~div_out;
      end else begin
        div_cnt++;
      end
    end
    // a rise produced by the last update above has not yet been driven
    if (div_cnt == 0 && div_out) rises--;
    n_checks++;
    if (bus.count_bcd !== to_bcd(rises)) begin
      n_fail++;
      $display("FAIL divider_chain count=%h required %h", bus.count_bcd, to_bcd(rises));
    end
    $display("test_divider rises=%0d count=%h", rises, bus.count_bcd);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.slow_clk = ($urandom_range(0, 2) != 0) ? ~bus.slow_clk : bus.slow_clk;
      bus.enable   = ($urandom_range(0, 7) != 0);
      bus.up_down  = ($urandom_range(0, 2) != 0);
      bus.clear    = ($urandom_range(0, 63) == 0);
      tick();
      n_checks++;
      if (bus.count_bcd !== to_bcd(m_count) || bus.carry !== m_carry ||
          bus.anodes !== m_anodes || bus.segments !== m_seg) begin
        n_fail++;
        $display("FAIL random i=%0d count=%h carry=%b an=%b seg=%h required %h/%b/%b/%h",
                 i, bus.count_bcd, bus.carry, bus.anodes, bus.segments,
                 to_bcd(m_count), m_carry, m_anodes, m_seg);
      end
    end
    bus.clear = 1'b0;
    $display("test_random done count=%h", bus.count_bcd);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_clear_priority();
    test_scan();
    test_reset_mid();
    test_divider();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
